// File: rtl/nf_rf_arb_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents:
//   NF_REQ_WB / NF_REQ_LD : requester indices (pipeline writeback / load-CSR unit)
//   NF_CNT_W              : width of the simultaneous-request statistics counter
//   nf_gnt_t              : grant descriptor (valid + winning requester index)
//   nf_sat_inc            : saturating increment for the statistics counter
package nf_rf_arb_pkg;

    localparam logic NF_REQ_WB = 1'b0;
    localparam logic NF_REQ_LD = 1'b1;

    localparam int NF_CNT_W = 16;

    typedef logic [NF_CNT_W-1:0] nf_cnt_t;

    typedef struct packed {
        logic vld;   // a requester was acknowledged this cycle
        logic idx;   // which one (NF_REQ_WB / NF_REQ_LD)
    } nf_gnt_t;

    // Sticks at all-ones instead of wrapping back to zero.
    function automatic nf_cnt_t nf_sat_inc(input nf_cnt_t c);
        return (c == '1) ? c : c + nf_cnt_t'(1);
    endfunction

endpackage

// File: rtl/nf_register.sv
// Plain D register with asynchronous active-high reset to a parameterised value.
// Latency: 1 cycle, d sampled on every rising edge.
// Backpressure: none, always loads.
//
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   d          : next value
//   q          : registered value, rst_val while reset is high
module nf_register #(
    parameter int               width   = 32,
    parameter logic [width-1:0] rst_val = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= rst_val;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/nf_register_we.sv
// D register with load enable and asynchronous active-high reset.
// Latency: 1 cycle when we=1; otherwise q holds.
// Backpressure: none; the enable is the only qualifier.
//
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   we         : load enable
//   d          : value loaded when we=1
//   q          : registered value, rst_val while reset is high
module nf_register_we #(
    parameter int               width   = 32,
    parameter logic [width-1:0] rst_val = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= rst_val;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/nf_rf_arb_rr.sv
// Two-way round-robin grant logic for register-file writes.
// Latency: acks are combinational in the request cycle; the pointer updates on the next edge.
// Backpressure: rf_busy suppresses all acks and freezes the pointer.
//
// Ports:
//   clk, reset     : clock and asynchronous active-high reset
//   req_0, req_1   : write requests (writeback / load-CSR unit)
//   rf_busy        : register file refuses writes this cycle
//   ack_0, ack_1   : request accepted this cycle (at most one high)
//   gnt            : grant descriptor for the output stage
module nf_rf_arb_rr
    import nf_rf_arb_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    req_0,
    input  logic    req_1,
    input  logic    rf_busy,
    output logic    ack_0,
    output logic    ack_1,
    output nf_gnt_t gnt
);

    // Index of the requester granted most recently. Resetting it to the
    // load unit makes the first contended grant after reset go to writeback.
    logic lg;

    always_comb begin
        ack_0 = 1'b0;
        ack_1 = 1'b0;
        // Reset gates the acks so nothing is accepted while the pipe is being cleared.
        if (!reset && !rf_busy) begin
            if (req_0 && req_1) begin
                // Contention: the side not served last wins.
                if (lg == NF_REQ_LD) begin
                    ack_0 = 1'b1;
                end else begin
                    ack_1 = 1'b1;
                end
            end else begin
                ack_0 = req_0;
                ack_1 = req_1;
            end
        end
        gnt.vld = ack_0 | ack_1;
        gnt.idx = ack_1 ? NF_REQ_LD : NF_REQ_WB;
    end

    // Every grant moves the pointer, uncontended ones included, so a
    // requester that was just served alone loses the next tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lg <= NF_REQ_LD;
        end else if (gnt.vld) begin
            lg <= gnt.idx;
        end
    end

endmodule

// File: rtl/nf_rf_wr_arb.sv
// Arbitrates two register-file write requesters onto a single write port.
// Latency: ack in the request cycle, rf_we/rf_wa/rf_wd one cycle later.
// Backpressure: rf_busy holds off every ack; requesters keep req/wa/wd stable until acked.
//
// Ports:
//   clk, reset        : clock and asynchronous active-high reset
//   req_0/wa_0/wd_0   : writeback requester (request, address, data)
//   req_1/wa_1/wd_1   : load/CSR requester (request, address, data)
//   ack_0, ack_1      : combinational accept, at most one per cycle
//   rf_busy           : register file cannot take a write this cycle
//   rf_we/rf_wa/rf_wd : registered write port toward the register file
//   conflict_cnt      : saturating count of contended cycles
//                       (only when NF_RF_WR_ARB_STAT_EN is defined)
//
// Build option: define NF_RF_WR_ARB_STAT_EN to add conflict_cnt and its counter.
module nf_rf_wr_arb
    import nf_rf_arb_pkg::*;
#(
    parameter int width = 32,
    parameter int aw    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_0,
    input  logic [aw-1:0]    wa_0,
    input  logic [width-1:0] wd_0,
    input  logic             req_1,
    input  logic [aw-1:0]    wa_1,
    input  logic [width-1:0] wd_1,
    output logic             ack_0,
    output logic             ack_1,
    input  logic             rf_busy,
    output logic             rf_we,
    output logic [aw-1:0]    rf_wa,
    output logic [width-1:0] rf_wd
`ifdef NF_RF_WR_ARB_STAT_EN
    ,
    output logic [NF_CNT_W-1:0] conflict_cnt
`endif
);

    nf_gnt_t          gnt;
    logic [aw-1:0]    sel_wa;
    logic [width-1:0] sel_wd;
    logic             wr_vld;

    nf_rf_arb_rr u_rr (
        .clk     (clk),
        .reset   (reset),
        .req_0   (req_0),
        .req_1   (req_1),
        .rf_busy (rf_busy),
        .ack_0   (ack_0),
        .ack_1   (ack_1),
        .gnt     (gnt)
    );

    always_comb begin
        sel_wa = (gnt.idx == NF_REQ_LD) ? wa_1 : wa_0;
        sel_wd = (gnt.idx == NF_REQ_LD) ? wd_1 : wd_0;
        // x0 is hardwired zero: the write is acked (so the requester moves on)
        // but never reaches the register file.
        wr_vld = gnt.vld && (sel_wa != '0);
    end

    nf_register #(
        .width (1)
    ) u_we_q (
        .clk   (clk),
        .reset (reset),
        .d     (wr_vld),
        .q     (rf_we)
    );

    // Address/data only load on a real write, so they hold across idle
    // cycles and across dropped x0 writes.
    nf_register_we #(
        .width (aw)
    ) u_wa_q (
        .clk   (clk),
        .reset (reset),
        .we    (wr_vld),
        .d     (sel_wa),
        .q     (rf_wa)
    );

    nf_register_we #(
        .width (width)
    ) u_wd_q (
        .clk   (clk),
        .reset (reset),
        .we    (wr_vld),
        .d     (sel_wd),
        .q     (rf_wd)
    );

`ifdef NF_RF_WR_ARB_STAT_EN
    nf_cnt_t cnt_q;

    // Counts cycles where both sides wanted the port and one had to wait;
    // busy cycles are not contention because nobody was served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (req_0 && req_1 && !rf_busy) begin
            cnt_q <= nf_sat_inc(cnt_q);
        end
    end

    assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_nf_rf_wr_arb.sv
module tb_nf_rf_wr_arb;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_0, req_1, rf_busy;
    logic [AW-1:0] wa_0, wa_1;
    logic [W-1:0]  wd_0, wd_1;
    logic          ack_0, ack_1, rf_we;
    logic [AW-1:0] rf_wa;
    logic [W-1:0]  rf_wd;
`ifdef NF_RF_WR_ARB_STAT_EN
    logic [15:0]   conflict_cnt;
`endif

    nf_rf_wr_arb #(.width(W), .aw(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_0        (req_0),
        .wa_0         (wa_0),
        .wd_0         (wd_0),
        .req_1        (req_1),
        .wa_1         (wa_1),
        .wd_1         (wd_1),
        .ack_0        (ack_0),
        .ack_1        (ack_1),
        .rf_busy      (rf_busy),
        .rf_we        (rf_we),
        .rf_wa        (rf_wa),
        .rf_wd        (rf_wd)
`ifdef NF_RF_WR_ARB_STAT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Requester-side state: a pending write stays presented until acked;
    // keep=1 makes the requester re-present the same write after each ack.
    logic          pend [2];
    logic          keep [2];
    logic [AW-1:0] q_wa [2];
    logic [W-1:0]  q_wd [2];
    logic          busy_q;

    // Reference model: who was served last, what the write port should
    // show next cycle, and how many contended cycles have been seen.
    int            m_last;
    logic          m_we;
    logic [AW-1:0] m_wa;
    logic [W-1:0]  m_wd;
    int            m_cnt;
    int            obs_gnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 1;
        m_we   = 1'b0;
        m_wa   = '0;
        m_wd   = '0;
        m_cnt  = 0;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 1'b0;
            keep[r] = 1'b0;
            q_wa[r] = '0;
            q_wd[r] = '0;
        end
    endtask

    task automatic set_req(input int r, input logic [AW-1:0] a, input logic [W-1:0] d, input logic k);
        pend[r] = 1'b1;
        keep[r] = k;
        q_wa[r] = a;
        q_wd[r] = d;
    endtask

    // One clock cycle: drive on the falling edge, check 1 ns later, then
    // advance the model and return on the rising edge.
    task automatic tick();
        int want;
        @(negedge clk);
        rf_busy = busy_q;
        req_0 = pend[0]; wa_0 = q_wa[0]; wd_0 = q_wd[0];
        req_1 = pend[1]; wa_1 = q_wa[1]; wd_1 = q_wd[1];
        #1;
        want = -1;
        if (!busy_q) begin
            if (pend[0] && pend[1]) want = 1 - m_last;
            else if (pend[0])       want = 0;
            else if (pend[1])       want = 1;
        end
        chk("ack_0", 64'(ack_0), 64'(want == 0));
        chk("ack_1", 64'(ack_1), 64'(want == 1));
        chk("rf_we", 64'(rf_we), 64'(m_we));
        if (m_we) begin
            chk("rf_wa", 64'(rf_wa), 64'(m_wa));
            chk("rf_wd", 64'(rf_wd), 64'(m_wd));
        end
`ifdef NF_RF_WR_ARB_STAT_EN
        chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
`endif
        obs_gnt = ack_1 ? 1 : (ack_0 ? 0 : -1);
        if (pend[0] && pend[1] && !busy_q && m_cnt < 65535) m_cnt++;
        m_we = 1'b0;
        if (want >= 0) begin
            m_last = want;
            if (q_wa[want] != '0) begin
                m_we = 1'b1;
                m_wa = q_wa[want];
                m_wd = q_wd[want];
            end
            if (!keep[want]) pend[want] = 1'b0;
        end
        @(posedge clk);
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [W-1:0]  rd;

        reset = 1'b1;
        rf_busy = 1'b0; busy_q = 1'b0;
        req_0 = 1'b1; req_1 = 1'b1;
        wa_0 = 5'd4; wa_1 = 5'd5; wd_0 = '1; wd_1 = '1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with both requests high to show acks are gated.
        chk("rst_rf_we", 64'(rf_we), 64'(0));
        chk("rst_rf_wa", 64'(rf_wa), 64'(0));
        chk("rst_rf_wd", 64'(rf_wd), 64'(0));
        chk("rst_ack_0", 64'(ack_0), 64'(0));
        chk("rst_ack_1", 64'(ack_1), 64'(0));
`ifdef NF_RF_WR_ARB_STAT_EN
        chk("rst_cnt", 64'(conflict_cnt), 64'(0));
`endif
        @(negedge clk);
        req_0 = 1'b0; req_1 = 1'b0;
        reset = 1'b0;

        // Single request from writeback: same-cycle ack, write one cycle later.
        set_req(0, 5'd3, 32'hA5A5_0001, 1'b0);
        tick();
        chk("single_ack", 64'(obs_gnt), 64'(0));
        #1;
        chk("single_we", 64'(rf_we), 64'(1));
        chk("single_wa", 64'(rf_wa), 64'(3));
        chk("single_wd", 64'(rf_wd), 64'(32'hA5A5_0001));

        // Write to x0 from the load unit: acked but filtered.
        set_req(1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        tick();
        chk("x0_ack", 64'(obs_gnt), 64'(1));
        #1;
        chk("x0_we", 64'(rf_we), 64'(0));

        // Sustained contention: strict alternation starting with writeback.
        set_req(0, 5'd1, 32'h0000_0101, 1'b1);
        set_req(1, 5'd2, 32'h0000_0202, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("alt_ack", 64'(obs_gnt), 64'(i % 2));
            #1;
            chk("alt_we", 64'(rf_we), 64'(1));
            chk("alt_wa", 64'(rf_wa), 64'((i % 2 == 1) ? 2 : 1));
        end

        // Busy register file stalls both, then the side not served last wins.
        set_req(0, 5'd9, 32'h0000_0909, 1'b0);
        set_req(1, 5'd10, 32'h0000_0A0A, 1'b0);
        busy_q = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_nogrant", 64'(obs_gnt), 64'(-1));
        end
        busy_q = 1'b0;
        tick();
        chk("busy_release", 64'(obs_gnt), 64'(0));
        tick();
        chk("busy_second", 64'(obs_gnt), 64'(1));

        // Asynchronous reset in the cycle after a grant: the write is lost.
        set_req(0, 5'd7, 32'h0000_0777, 1'b0);
        tick();
        #1;
        chk("pre_rst_we", 64'(rf_we), 64'(1));
        req_0 = 1'b1; req_1 = 1'b1;
        reset = 1'b1;
        #1;
        chk("arst_we", 64'(rf_we), 64'(0));
        chk("arst_wa", 64'(rf_wa), 64'(0));
        chk("arst_wd", 64'(rf_wd), 64'(0));
        chk("arst_ack_0", 64'(ack_0), 64'(0));
        chk("arst_ack_1", 64'(ack_1), 64'(0));
`ifdef NF_RF_WR_ARB_STAT_EN
        chk("arst_cnt", 64'(conflict_cnt), 64'(0));
`endif
        @(negedge clk);
        req_0 = 1'b0; req_1 = 1'b0;
        reset = 1'b0;
        model_reset();

        // First contended arbitration after reset goes to writeback.
        set_req(0, 5'd11, 32'h0000_0B0B, 1'b0);
        set_req(1, 5'd12, 32'h0000_0C0C, 1'b0);
        tick();
        chk("post_rst_first", 64'(obs_gnt), 64'(0));
        tick();
        chk("post_rst_second", 64'(obs_gnt), 64'(1));

        // Random traffic checked cycle by cycle against the model.
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 3) != 0) begin
                    ra = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    rd = $urandom;
                    set_req(r, ra, rd, 1'b0);
                end
            end
            busy_q = ($urandom_range(0, 4) == 0);
            tick();
        end
        busy_q = 1'b0;
        repeat (3) tick();

`ifdef NF_RF_WR_ARB_STAT_EN
        // Long contention run saturates the counter, which then holds.
        set_req(0, 5'd13, 32'h0000_0D0D, 1'b1);
        set_req(1, 5'd14, 32'h0000_0E0E, 1'b1);
        repeat (70000) tick();
        #1;
        chk("cnt_sat", 64'(conflict_cnt), 64'(16'hFFFF));
        repeat (3) tick();
        #1;
        chk("cnt_hold", 64'(conflict_cnt), 64'(16'hFFFF));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nf_rf_wr_arb.md
NF_RF_WR_ARB -- requirements
Module: nf_rf_wr_arb

Interface
REQ-001 Parameter: width, 32, register-file data width in bits.
REQ-002 Parameter: aw, 5, register-file address width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset; no other clock or reset exists.
REQ-005 req_0 / req_1  input  1 each  write request from requester 0 (pipeline writeback) / requester 1 (load/CSR unit).
REQ-006 wa_0 / wa_1  input  aw each  destination address per requester.
REQ-007 wd_0 / wd_1  input  width each  write data per requester.
REQ-008 ack_0 / ack_1  output  1 each  request accepted this cycle.
REQ-009 rf_busy  input  1  register file cannot accept a write this cycle.
REQ-010 rf_we  output  1  register-file write enable.
REQ-011 rf_wa  output  aw  register-file write address.
REQ-012 rf_wd  output  width  register-file write data.
REQ-013 conflict_cnt  output  16  simultaneous-request counter; present only with NF_RF_WR_ARB_STAT_EN.

Function
REQ-014 Handshake: requester holds req_x, wa_x, wd_x stable until ack_x; deasserting before ack is illegal.
REQ-015 ack_0/ack_1 are combinational from req_x, rf_busy and the last-grant pointer lg; at most one ack per cycle.
REQ-016 rf_busy=1: both acks 0, no grant, lg unchanged.
REQ-017 Single request, rf_busy=0: that requester acked same cycle.
REQ-018 Both requests, rf_busy=0: grant requester !lg (round-robin); lg <= granted index on the next edge.
REQ-019 lg updates on every grant, including single-request grants.
REQ-020 Output stage registered: grant in cycle N -> rf_we=1, rf_wa/rf_wd = granted wa/wd in cycle N+1; one-cycle latency.
REQ-021 No grant in cycle N -> rf_we=0 in cycle N+1; rf_wa/rf_wd hold previous values.
REQ-022 x0 filter: granted wa==0 -> ack issued and lg updated, but rf_we=0 in N+1.
REQ-023 Same address from both requesters in one cycle: granted write lands first, other lands in a later cycle; no merging.
REQ-024 Sustained requests from both sides: grants strictly alternate, no starvation beyond one cycle.

Reset
REQ-025 reset=1 asynchronously forces rf_we=0, rf_wa=0, rf_wd=0, lg=1, conflict_cnt=0; ack_0/ack_1 = 0 while reset asserted.
REQ-026 Reset mid-operation: pending (unacked) requests are dropped; an ack-ed write whose rf_we has not yet appeared is lost.
REQ-027 First arbitration after reset with both requests grants requester 0.

Configuration
REQ-028 Macro NF_RF_WR_ARB_STAT_EN defined: conflict_cnt port exists; increments by 1 each cycle with req_0=req_1=1 and rf_busy=0; saturates at 16'hFFFF.
REQ-029 Macro undefined: port, counter and logic absent; all other behaviour identical.

Structure
REQ-030 Shared package nf_rf_arb_pkg holds requester index constants (NF_REQ_WB=0, NF_REQ_LD=1) and the counter width constant (16).
REQ-031 Round-robin pointer plus grant logic is one sub-module nf_rf_arb_rr; output stage uses the existing nf_register_we/nf_register primitives, adapted to active-high reset inside this block.

Verification
REQ-032 Reset released, req_0=1 wa_0=3 wd_0=32'hA5A5_0001 -> ack_0 same cycle; next cycle rf_we=1 rf_wa=3 rf_wd=32'hA5A5_0001.
REQ-033 Both req held 4 cycles, wa_0=1, wa_1=2 -> acks 0,1,0,1 (each requester re-presents after ack); rf_wa 1,2,1,2 one cycle later.
REQ-034 rf_busy=1 for 3 cycles with both req -> no acks, rf_we=0; rf_busy drop -> grant to !lg.
REQ-035 req_1=1 wa_1=0 wd_1=32'hFFFF_FFFF -> ack_1=1, rf_we stays 0 next cycle.
REQ-036 reset pulse in the cycle after a grant -> rf_we=0, lg=1, conflict_cnt=0 immediately (asynchronous).
REQ-037 STAT_EN build: 70000 cycles both req, rf_busy=0 -> conflict_cnt=16'hFFFF, holds.
